// File: rtl/mixer_i2s_tx.sv
// mixer_i2s_tx
//   Stereo output stage fed by the mixer core. Gained left/right pairs are
//   buffered in a small FIFO and serialized as a standard I2S stream.
//   FIFO overflow (dropped pair) and underflow (frame with no data) are
//   reported as sticky status bits.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   ing_left/ing_right  signed samples of one stereo pair
//   ing_valid           pair valid (upstream ignores ing_ready)
//   ing_ready           FIFO not full
//   i2s_bclk            bit clock, period 2*BCLK_DIV_P clk
//   i2s_lrclk           word select, 0 = left, 1 = right
//   i2s_sdata           serial data, MSB first, changes after bclk falls
//   cr_enable           serializer run enable
//   cr_clear_status     one-cycle pulse clearing the sticky flags
//   sr_overflow         sticky: pair dropped on a full FIFO
//   sr_underflow        sticky: frame started with the FIFO empty
module mixer_i2s_tx #(
  parameter int AUDIO_WIDTH_P = 24,
  parameter int SLOT_WIDTH_P  = 32,
  parameter int BCLK_DIV_P    = 4,
  parameter int FIFO_DEPTH_P  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AUDIO_WIDTH_P-1:0] ing_left,
  input  logic [AUDIO_WIDTH_P-1:0] ing_right,
  input  logic                     ing_valid,
  output logic                     ing_ready,
  output logic                     i2s_bclk,
  output logic                     i2s_lrclk,
  output logic                     i2s_sdata,
  input  logic                     cr_enable,
  input  logic                     cr_clear_status,
  output logic                     sr_overflow,
  output logic                     sr_underflow
);

  localparam int FRAME_W = 2 * SLOT_WIDTH_P;
  localparam int PAIR_W  = 2 * AUDIO_WIDTH_P;
  localparam int DIV_W   = $clog2(BCLK_DIV_P);
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int PTR_W   = $clog2(FIFO_DEPTH_P);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV_P - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] LR_FIRST = BIT_W'(SLOT_WIDTH_P - 1);
  localparam logic [BIT_W-1:0] LR_LAST  = BIT_W'(FRAME_W - 2);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH_P);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [PAIR_W-1:0]   fifo_mem_r [FIFO_DEPTH_P];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    count_r, count_nxt_s;
  logic                ready_r;
  logic [DIV_W-1:0]    div_r;
  logic                bclk_r;
  logic [BIT_W-1:0]    bit_r;
  logic [FRAME_W-1:0]  frame_r;
  logic                lrclk_r, sdata_r, overflow_r, underflow_r;
  logic                empty_s, wr_en_s, drop_s, pop_s, underflow_evt_s;
  logic                bclk_fall_s, frame_end_s, frame_start_s;

  // Lay a pair out as one frame: each sample MSB-aligned in its slot, zero padded.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [PAIR_W-1:0] pair);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[FRAME_W-1 -: AUDIO_WIDTH_P]      = pair[PAIR_W-1 -: AUDIO_WIDTH_P];
    f[SLOT_WIDTH_P-1 -: AUDIO_WIDTH_P] = pair[AUDIO_WIDTH_P-1:0];
    return f;
  endfunction

  assign empty_s         = (count_r == CNT_ZERO);
  assign wr_en_s         = ing_valid & ready_r;
  assign drop_s          = ing_valid & ~ready_r;
  assign bclk_fall_s     = (state_r == ST_RUN) & (div_r == DIV_LAST) & bclk_r;
  assign frame_end_s     = bclk_fall_s & (bit_r == BIT_LAST);
  // Emptiness is judged on the registered count, so a pair written in the
  // frame-start cycle itself is not popped until the following frame.
  assign pop_s           = frame_start_s & ~empty_s;
  assign underflow_evt_s = frame_start_s & empty_s;

  // Next state and frame-start decode; a disable only takes effect at frame end.
  always_comb begin
    state_nxt_s   = state_r;
    frame_start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cr_enable) begin
          state_nxt_s   = ST_RUN;
          frame_start_s = 1'b1;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (frame_end_s) begin
          if (cr_enable) begin
            state_nxt_s   = ST_RUN;
            frame_start_s = 1'b1;
          end else begin
            state_nxt_s   = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FIFO occupancy after this cycle's write and pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      ready_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_en_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      count_r  <= count_nxt_s;
      ready_r  <= (count_nxt_s != CNT_FULL);
    end
  end

  // FIFO storage; contents are don't-care while the pointers mark them empty.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      fifo_mem_r[wr_ptr_r] <= {ing_left, ing_right};
    end
  end

  // Bit-clock divider and bit counter; both restart at every frame start and in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r  <= DIV_ZERO;
      bclk_r <= 1'b0;
      bit_r  <= BIT_ZERO;
    end else if (frame_start_s || (state_nxt_s == ST_IDLE)) begin
      div_r  <= DIV_ZERO;
      bclk_r <= 1'b0;
      bit_r  <= BIT_ZERO;
    end else if (div_r == DIV_LAST) begin
      div_r  <= DIV_ZERO;
      bclk_r <= ~bclk_r;
      bit_r  <= bclk_r ? (bit_r + BIT_ONE) : bit_r;
    end else begin
      div_r  <= div_r + DIV_ONE;
      bclk_r <= bclk_r;
      bit_r  <= bit_r;
    end
  end

  // Frame shift register: MSB is always the bit for the current bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_r <= '0;
    end else if (frame_start_s) begin
      frame_r <= pop_s ? build_frame(fifo_mem_r[rd_ptr_r]) : '0;
    end else if (bclk_fall_s) begin
      frame_r <= {frame_r[FRAME_W-2:0], 1'b0};
    end else begin
      frame_r <= frame_r;
    end
  end

  // Serial outputs follow the bit counter by one clk; lrclk leads each slot by one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdata_r <= 1'b0;
      lrclk_r <= 1'b0;
    end else if (state_r == ST_RUN) begin
      sdata_r <= frame_r[FRAME_W-1];
      lrclk_r <= (bit_r >= LR_FIRST) && (bit_r <= LR_LAST);
    end else begin
      sdata_r <= 1'b0;
      lrclk_r <= 1'b0;
    end
  end

  // Sticky status; a set event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (cr_clear_status) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (underflow_evt_s) begin
        underflow_r <= 1'b1;
      end else if (cr_clear_status) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  assign ing_ready    = ready_r;
  assign i2s_bclk     = bclk_r;
  assign i2s_lrclk    = lrclk_r;
  assign i2s_sdata    = sdata_r;
  assign sr_overflow  = overflow_r;
  assign sr_underflow = underflow_r;

endmodule

// File: tb/tb_mixer_i2s_tx.sv
// tb_mixer_i2s_tx
//   Self-checking bench for mixer_i2s_tx. A queue model of the FIFO decides
//   which pair (or silence) each frame carries; the captured serial stream is
//   compared bit by bit against the I2S frame layout computed arithmetically.
module tb_mixer_i2s_tx;
  localparam int AW   = 24;
  localparam int SW   = 32;
  localparam int DIV  = 4;
  localparam int DEP  = 4;
  localparam int FB   = 2 * SW;
  localparam int FCLK = FB * 2 * DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ing_left = '0;
  logic [AW-1:0] ing_right = '0;
  logic          ing_valid = 1'b0;
  logic          ing_ready;
  logic          i2s_bclk, i2s_lrclk, i2s_sdata;
  logic          cr_enable = 1'b0;
  logic          cr_clear_status = 1'b0;
  logic          sr_overflow, sr_underflow;

  mixer_i2s_tx #(
    .AUDIO_WIDTH_P(AW),
    .SLOT_WIDTH_P (SW),
    .BCLK_DIV_P   (DIV),
    .FIFO_DEPTH_P (DEP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ing_left       (ing_left),
    .ing_right      (ing_right),
    .ing_valid      (ing_valid),
    .ing_ready      (ing_ready),
    .i2s_bclk       (i2s_bclk),
    .i2s_lrclk      (i2s_lrclk),
    .i2s_sdata      (i2s_sdata),
    .cr_enable      (cr_enable),
    .cr_clear_status(cr_clear_status),
    .sr_overflow    (sr_overflow),
    .sr_underflow   (sr_underflow)
  );

  always #5 clk = ~clk;

  // Posedge counter: at a negedge, cyc equals the number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stream capture: one sample of sdata/lrclk per bclk rising edge.
  bit   samp_sd[$];
  bit   samp_lr[$];
  int   rise_cyc[$];
  logic prev_bclk = 1'b0;
  always @(negedge clk) begin
    if (i2s_bclk && !prev_bclk) begin
      samp_sd.push_back(i2s_sdata);
      samp_lr.push_back(i2s_lrclk);
      rise_cyc.push_back(cyc);
    end
    prev_bclk <= i2s_bclk;
  end

  // Reference model: FIFO contents, frame payload list and sticky flags.
  logic [2*AW-1:0] mq[$];
  logic [2*AW-1:0] efr[$];
  bit              ovf_m = 1'b0;
  bit              unf_m = 1'b0;

  task automatic clr_mon();
    samp_sd.delete();
    samp_lr.delete();
    rise_cyc.delete();
    efr.delete();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset();
    cr_enable       = 1'b0;
    cr_clear_status = 1'b0;
    ing_valid       = 1'b0;
    rst_n           = 1'b0;
    mq.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    clr_mon();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Present one pair for a single cycle; called at a negedge.
  task automatic send_pair(input logic [AW-1:0] l, input logic [AW-1:0] r);
    bit acc;
    acc = (mq.size() < DEP);
    check_eq("ing_ready", 64'(ing_ready), 64'(acc));
    ing_left  = l;
    ing_right = r;
    ing_valid = 1'b1;
    if (acc) mq.push_back({l, r});
    else ovf_m = 1'b1;
    @(negedge clk);
    ing_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [AW-1:0] l, r;
    l = AW'($urandom);
    r = AW'($urandom);
    send_pair(l, r);
  endtask

  // Frame start in the model: transmit the oldest pair, or silence on empty.
  task automatic model_pop();
    if (mq.size() > 0) begin
      efr.push_back(mq.pop_front());
    end else begin
      efr.push_back('0);
      unf_m = 1'b1;
    end
  endtask

  task automatic pulse_clear();
    cr_clear_status = 1'b1;
    @(negedge clk);
    cr_clear_status = 1'b0;
    ovf_m = 1'b0;
    unf_m = 1'b0;
    check_eq("clr_overflow", 64'(sr_overflow), 64'(ovf_m));
    check_eq("clr_underflow", 64'(sr_underflow), 64'(unf_m));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_bclk"}, 64'(i2s_bclk), 64'(0));
    check_eq({tag, "_lrclk"}, 64'(i2s_lrclk), 64'(0));
    check_eq({tag, "_sdata"}, 64'(i2s_sdata), 64'(0));
  endtask

  // Compare every captured frame against the I2S layout of its expected pair.
  task automatic check_frames();
    logic [FB-1:0] exp_sd, exp_lr, act_sd, act_lr;
    logic [AW-1:0] l, r;
    check_eq("bit_count", 64'(samp_sd.size()), 64'(efr.size() * FB));
    for (int k = 0; k < efr.size(); k++) begin
      {l, r} = efr[k];
      for (int b = 0; b < FB; b++) begin
        if (b < AW) exp_sd[FB-1-b] = l[AW-1-b];
        else if (b >= SW && b < SW + AW) exp_sd[FB-1-b] = r[AW-1-(b-SW)];
        else exp_sd[FB-1-b] = 1'b0;
        exp_lr[FB-1-b] = (b >= SW - 1) && (b <= 2 * SW - 2);
        if (FB * k + b < samp_sd.size()) begin
          act_sd[FB-1-b] = samp_sd[FB*k+b];
          act_lr[FB-1-b] = samp_lr[FB*k+b];
        end else begin
          act_sd[FB-1-b] = 1'bx;
          act_lr[FB-1-b] = 1'bx;
        end
      end
      check_eq($sformatf("sdata_frame%0d", k), 64'(act_sd), 64'(exp_sd));
      check_eq($sformatf("lrclk_frame%0d", k), 64'(act_lr), 64'(exp_lr));
    end
  endtask

  // Enable, run n frames (optionally one random write per frame), stop at b=10 of the last.
  task automatic run_frames(input int n, input bit wr_each);
    int p0;
    clr_mon();
    cr_enable = 1'b1;
    p0 = cyc + 1;
    for (int k = 0; k < n; k++) begin
      model_pop();
      wait_until(p0 + FCLK * k + 2);
      check_eq("underflow", 64'(sr_underflow), 64'(unf_m));
      check_eq("overflow", 64'(sr_overflow), 64'(ovf_m));
      if (k == n - 1) begin
        wait_until(p0 + FCLK * k + 8 * 10 + 2);
        cr_enable = 1'b0;
      end
      if (wr_each) begin
        wait_until(p0 + FCLK * k + 200);
        send_rand();
      end
    end
    wait_until(p0 + FCLK * n + 40);
    check_idle("stopped");
    if (rise_cyc.size() >= 2) begin
      check_eq("bclk_first_rise", 64'(rise_cyc[0] - p0), 64'(DIV));
      check_eq("bclk_period", 64'(rise_cyc[1] - rise_cyc[0]), 64'(2 * DIV));
    end else begin
      check_eq("bclk_rises", 64'(rise_cyc.size()), 64'(2));
    end
    check_frames();
  endtask

  initial begin
    int p0;
    int cnt;

    // Reset values
    do_reset();
    check_idle("reset");
    check_eq("reset_ready", 64'(ing_ready), 64'(1));
    check_eq("reset_overflow", 64'(sr_overflow), 64'(0));
    check_eq("reset_underflow", 64'(sr_underflow), 64'(0));

    // Basic frame with a stop at b=10; the second pair must stay queued
    send_pair(24'h800001, 24'h7FFFFE);
    send_rand();
    run_frames(1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 3; i++) send_rand();
    check_eq("ready_after_refill", 64'(ing_ready), 64'(mq.size() < DEP));
    // Sustained one-pair-per-frame traffic
    run_frames(5, 1'b1);

    // Overflow: five back-to-back writes while disabled
    do_reset();
    for (int i = 0; i < 5; i++) send_rand();
    check_eq("overflow_set", 64'(sr_overflow), 64'(ovf_m));
    run_frames(5, 1'b0);
    pulse_clear();

    // Underflow, clear, then a late pair goes out in the next frame
    do_reset();
    cr_enable = 1'b1;
    p0 = cyc + 1;
    model_pop();
    wait_until(p0 + 2);
    check_eq("underflow_set", 64'(sr_underflow), 64'(unf_m));
    wait_until(p0 + 10);
    pulse_clear();
    wait_until(p0 + 100);
    send_rand();
    model_pop();
    wait_until(p0 + FCLK + 2);
    check_eq("underflow_kept_clear", 64'(sr_underflow), 64'(unf_m));
    wait_until(p0 + FCLK + 82);
    cr_enable = 1'b0;
    wait_until(p0 + 2 * FCLK + 40);
    check_frames();

    // Write on the frame-start cycle, then underflow coinciding with a clear
    do_reset();
    send_rand();
    cr_enable = 1'b1;
    p0 = cyc + 1;
    model_pop();
    wait_until(p0 + 100);
    send_rand();
    wait_until(p0 + FCLK - 1);
    model_pop();
    send_rand();
    check_eq("simul_overflow", 64'(sr_overflow), 64'(ovf_m));
    check_eq("simul_underflow", 64'(sr_underflow), 64'(unf_m));
    wait_until(p0 + 2 * FCLK - 1);
    model_pop();
    wait_until(p0 + 3 * FCLK - 1);
    model_pop();
    cr_clear_status = 1'b1;
    @(negedge clk);
    cr_clear_status = 1'b0;
    check_eq("underflow_beats_clear", 64'(sr_underflow), 64'(unf_m));
    check_eq("simul_overflow_end", 64'(sr_overflow), 64'(ovf_m));
    wait_until(p0 + 3 * FCLK + 82);
    cr_enable = 1'b0;
    wait_until(p0 + 4 * FCLK + 40);
    check_frames();

    // Reset at b=40 with three pairs queued
    do_reset();
    for (int i = 0; i < 3; i++) send_rand();
    cr_enable = 1'b1;
    p0 = cyc + 1;
    wait_until(p0 + 8 * 40 + 3);
    check_eq("lrclk_at_b40", 64'(i2s_lrclk), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    check_eq("async_reset_ready", 64'(ing_ready), 64'(1));
    check_eq("async_reset_underflow", 64'(sr_underflow), 64'(0));
    @(negedge clk);
    cr_enable = 1'b0;
    mq.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    clr_mon();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frames(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
